// File: rtl/exu_oitf_gen2.sv
// ---------------------------------------------------------------------------
// exu_oitf_gen2 -- outstanding-instruction track FIFO for the EXU.
//
// Every long-pipe instruction (LSU, later MULDIV) takes an entry at dispatch
// and receives that entry's index as its itag. Entries return strictly in
// dispatch order to the long-pipe write-back block. The dispatching
// instruction's rs1/rs2/rd are compared against all outstanding
// destinations so the dispatcher can stall on RAW/WAW hazards.
//
// Optional feature macro: EXU_OITF_FLUSH_EN
//   defined   -> flush_req port exists and clears the FIFO at the next edge
//   undefined -> no flush_req port; only rst_n clears the FIFO
//
// Parameters
//   DEPTH    number of entries (power of two, >= 2)
//   RFIDX_W  register index width
//   PTR_W    itag width, $clog2(DEPTH)
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   disp_ena / disp_ready            allocation request / accepted
//   disp_ptr                         itag for the allocating instruction
//   disp_i_rs1en/rs2en/rdwen         operand and destination enables
//   disp_i_rs1idx/rs2idx/rdidx       operand and destination indices
//   oitfrd_match_disprs1/rs2/rd      hazard hits against outstanding rd
//   ret_ena                          retire the oldest entry
//   ret_ptr / ret_rdwen / ret_rdidx  oldest entry itag and destination
//   oitf_empty / oitf_full           status
//   oitf_count                       valid entries, 0..DEPTH
//   flush_req                        clear everything (EXU_OITF_FLUSH_EN only)
// ---------------------------------------------------------------------------
module exu_oitf_gen2 #(
    parameter  int DEPTH   = 4,
    parameter  int RFIDX_W = 5,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               disp_ena,
    output logic               disp_ready,
    output logic [PTR_W-1:0]   disp_ptr,

    input  logic               disp_i_rs1en,
    input  logic               disp_i_rs2en,
    input  logic               disp_i_rdwen,
    input  logic [RFIDX_W-1:0] disp_i_rs1idx,
    input  logic [RFIDX_W-1:0] disp_i_rs2idx,
    input  logic [RFIDX_W-1:0] disp_i_rdidx,

    output logic               oitfrd_match_disprs1,
    output logic               oitfrd_match_disprs2,
    output logic               oitfrd_match_disprd,

    input  logic               ret_ena,
    output logic [PTR_W-1:0]   ret_ptr,
    output logic               ret_rdwen,
    output logic [RFIDX_W-1:0] ret_rdidx,

    output logic               oitf_empty,
    output logic               oitf_full,
    output logic [PTR_W:0]     oitf_count
`ifdef EXU_OITF_FLUSH_EN
    ,
    input  logic               flush_req
`endif
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    // Pointers carry their wrap flag as the extra MSB. Because DEPTH is a
    // power of two, a plain +1 on {flag, index} wraps the index from
    // DEPTH-1 to 0 and toggles the flag in the same step.
    logic [DEPTH-1:0]   vld_q,   vld_d;
    logic [DEPTH-1:0]   rdwen_q, rdwen_d;
    logic [RFIDX_W-1:0] rdidx_q [DEPTH];
    logic [RFIDX_W-1:0] rdidx_d [DEPTH];

    logic [PTR_W:0]     alc_ptr_q, alc_ptr_d;
    logic [PTR_W:0]     ret_ptr_q, ret_ptr_d;
    logic [PTR_W:0]     count_q,   count_d;

    logic [PTR_W-1:0]   alc_idx;
    logic [PTR_W-1:0]   ret_idx;
    logic               alc_flg;
    logic               ret_flg;

    logic               flush;
    logic               empty;
    logic               full;
    logic               alc_fire;
    logic               ret_fire;

`ifdef EXU_OITF_FLUSH_EN
    assign flush = flush_req;
`else
    assign flush = 1'b0;
`endif

    assign alc_idx = alc_ptr_q[PTR_W-1:0];
    assign ret_idx = ret_ptr_q[PTR_W-1:0];
    assign alc_flg = alc_ptr_q[PTR_W];
    assign ret_flg = ret_ptr_q[PTR_W];

    // -----------------------------------------------------------------------
    // Status and handshakes
    // -----------------------------------------------------------------------
    assign empty = (alc_idx == ret_idx) && (alc_flg == ret_flg);
    assign full  = (alc_idx == ret_idx) && (alc_flg != ret_flg);

    // A flush cycle refuses allocation so the dispatcher never believes an
    // instruction was recorded when the flush is about to discard it.
    assign disp_ready = ~full & ~flush;
    assign alc_fire   = disp_ena & disp_ready;
    assign ret_fire   = ret_ena & ~empty;

    assign disp_ptr   = alc_idx;
    assign ret_ptr    = ret_idx;
    assign ret_rdidx  = rdidx_q[ret_idx];
    assign ret_rdwen  = rdwen_q[ret_idx] & vld_q[ret_idx];

    assign oitf_empty = empty;
    assign oitf_full  = full;
    assign oitf_count = count_q;

    // -----------------------------------------------------------------------
    // Hazard compare against registered entries only. An entry retiring this
    // cycle is still seen as outstanding, which can cost one stall cycle but
    // never lets a hazard slip through.
    // -----------------------------------------------------------------------
    logic hit_rs1;
    logic hit_rs2;
    logic hit_rd;

    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        hit_rd  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            // rdwen was stored as 0 for rd == x0, so x0 can never hit here.
            if (vld_q[i] && rdwen_q[i]) begin
                if (rdidx_q[i] == disp_i_rs1idx) hit_rs1 = 1'b1;
                if (rdidx_q[i] == disp_i_rs2idx) hit_rs2 = 1'b1;
                if (rdidx_q[i] == disp_i_rdidx)  hit_rd  = 1'b1;
            end
        end
    end

    assign oitfrd_match_disprs1 = disp_i_rs1en & hit_rs1;
    assign oitfrd_match_disprs2 = disp_i_rs2en & hit_rs2;
    assign oitfrd_match_disprd  = disp_i_rdwen & hit_rd;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal written here is given its hold value first, so no
    // path through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        vld_d     = vld_q;
        rdwen_d   = rdwen_q;
        rdidx_d   = rdidx_q;
        alc_ptr_d = alc_ptr_q;
        ret_ptr_d = ret_ptr_q;
        count_d   = count_q;

        if (flush) begin
            // Return to exactly the reset picture, including the data fields
            // so ret_rdidx reads 0 afterwards just as it does out of reset.
            vld_d     = '0;
            rdwen_d   = '0;
            for (int i = 0; i < DEPTH; i++) begin
                rdidx_d[i] = '0;
            end
            alc_ptr_d = '0;
            ret_ptr_d = '0;
            count_d   = '0;
        end else begin
            // Allocation needs not-full and retirement needs not-empty, so
            // both can never address the same slot in one cycle.
            if (alc_fire) begin
                vld_d[alc_idx]   = 1'b1;
                rdwen_d[alc_idx] = disp_i_rdwen & (disp_i_rdidx != '0);
                rdidx_d[alc_idx] = disp_i_rdidx;
                alc_ptr_d        = alc_ptr_q + 1'b1;
            end

            if (ret_fire) begin
                vld_d[ret_idx] = 1'b0;
                ret_ptr_d      = ret_ptr_q + 1'b1;
            end

            unique case ({alc_fire, ret_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the entry array is small and its rdidx/rdwen are visible
            // on ret_* straight out of reset, so the whole array is reset,
            // not just the valid bits.
            vld_q     <= '0;
            rdwen_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rdidx_q[i] <= '0;
            end
            alc_ptr_q <= '0;
            ret_ptr_q <= '0;
            count_q   <= '0;
        end else begin
            vld_q     <= vld_d;
            rdwen_q   <= rdwen_d;
            rdidx_q   <= rdidx_d;
            alc_ptr_q <= alc_ptr_d;
            ret_ptr_q <= ret_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_exu_oitf_gen2.sv
// ---------------------------------------------------------------------------
// tb_exu_oitf_gen2 -- directed bench for exu_oitf_gen2 (DEPTH=4, RFIDX_W=5).
//
// Each accepted allocation pushes the hand-given itag and destination into
// a scoreboard queue; a monitor pops and compares whenever the DUT retires
// an entry. Status, itag and hazard outputs are compared directly against
// hand-computed constants. Define EXU_OITF_FLUSH_EN to cover the flush path.
// ---------------------------------------------------------------------------
module tb_exu_oitf_gen2;

    localparam int DEPTH   = 4;
    localparam int RFIDX_W = 5;
    localparam int PTR_W   = 2;

    typedef struct {
        logic [PTR_W-1:0]   ptr;
        logic               rdwen;
        logic [RFIDX_W-1:0] rdidx;
    } ret_exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               disp_ena;
    logic               disp_ready;
    logic [PTR_W-1:0]   disp_ptr;
    logic               disp_i_rs1en, disp_i_rs2en, disp_i_rdwen;
    logic [RFIDX_W-1:0] disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx;
    logic               oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd;
    logic               ret_ena;
    logic [PTR_W-1:0]   ret_ptr;
    logic               ret_rdwen;
    logic [RFIDX_W-1:0] ret_rdidx;
    logic               oitf_empty, oitf_full;
    logic [PTR_W:0]     oitf_count;
`ifdef EXU_OITF_FLUSH_EN
    logic               flush_req;
`endif

    ret_exp_t exp_q[$];
    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    exu_oitf_gen2 #(.DEPTH(DEPTH), .RFIDX_W(RFIDX_W)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .disp_ena             (disp_ena),
        .disp_ready           (disp_ready),
        .disp_ptr             (disp_ptr),
        .disp_i_rs1en         (disp_i_rs1en),
        .disp_i_rs2en         (disp_i_rs2en),
        .disp_i_rdwen         (disp_i_rdwen),
        .disp_i_rs1idx        (disp_i_rs1idx),
        .disp_i_rs2idx        (disp_i_rs2idx),
        .disp_i_rdidx         (disp_i_rdidx),
        .oitfrd_match_disprs1 (oitfrd_match_disprs1),
        .oitfrd_match_disprs2 (oitfrd_match_disprs2),
        .oitfrd_match_disprd  (oitfrd_match_disprd),
        .ret_ena              (ret_ena),
        .ret_ptr              (ret_ptr),
        .ret_rdwen            (ret_rdwen),
        .ret_rdidx            (ret_rdidx),
        .oitf_empty           (oitf_empty),
        .oitf_full            (oitf_full),
        .oitf_count           (oitf_count)
`ifdef EXU_OITF_FLUSH_EN
        ,
        .flush_req            (flush_req)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // One clock of stimulus. When an allocation is expected to be accepted
    // the hand-given itag and destination go into the scoreboard.
    task automatic do_cycle(input bit alc, input bit wen, input logic [RFIDX_W-1:0] rd,
                            input bit acc, input logic [PTR_W-1:0] exp_ptr, input bit ret);
        ret_exp_t e;
        disp_ena     = alc;
        disp_i_rdwen = wen;
        disp_i_rdidx = rd;
        ret_ena      = ret;
        #1;
        if (alc) begin
            check("disp_ready", disp_ready, acc);
            if (acc) begin
                check("disp_ptr", disp_ptr, exp_ptr);
                e.ptr   = exp_ptr;
                e.rdwen = wen && (rd != 0);
                e.rdidx = rd;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        disp_ena     = 1'b0;
        disp_i_rdwen = 1'b0;
        disp_i_rdidx = '0;
        ret_ena      = 1'b0;
    endtask

    task automatic chk_status(input string tag, input bit e_empty, input bit e_full, input int e_cnt);
        check({tag, "_empty"}, oitf_empty, e_empty);
        check({tag, "_full"},  oitf_full,  e_full);
        check({tag, "_count"}, oitf_count, e_cnt);
        check({tag, "_ready"}, disp_ready, !e_full);
    endtask

    task automatic chk_haz(input string tag,
                           input bit en1, input logic [RFIDX_W-1:0] rs1,
                           input bit en2, input logic [RFIDX_W-1:0] rs2,
                           input bit wen, input logic [RFIDX_W-1:0] rd,
                           input bit m1, input bit m2, input bit md);
        disp_i_rs1en  = en1; disp_i_rs1idx = rs1;
        disp_i_rs2en  = en2; disp_i_rs2idx = rs2;
        disp_i_rdwen  = wen; disp_i_rdidx  = rd;
        #1;
        check({tag, "_rs1"}, oitfrd_match_disprs1, m1);
        check({tag, "_rs2"}, oitfrd_match_disprs2, m2);
        check({tag, "_rd"},  oitfrd_match_disprd,  md);
        disp_i_rs1en = 1'b0; disp_i_rs1idx = '0;
        disp_i_rs2en = 1'b0; disp_i_rs2idx = '0;
        disp_i_rdwen = 1'b0; disp_i_rdidx  = '0;
    endtask

    // Scoreboard monitor: a retirement is presented whenever ret_ena is high
    // and the DUT is not empty; its outputs must match the oldest record.
    initial begin
        ret_exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ret_ena && !oitf_empty
`ifdef EXU_OITF_FLUSH_EN
                && !flush_req
`endif
               ) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ret_ptr",   ret_ptr,   e.ptr);
                    check("ret_rdidx", ret_rdidx, e.rdidx);
                    check("ret_rdwen", ret_rdwen, e.rdwen);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        disp_ena = 1'b0; ret_ena = 1'b0;
        disp_i_rs1en = 1'b0; disp_i_rs2en = 1'b0; disp_i_rdwen = 1'b0;
        disp_i_rs1idx = '0; disp_i_rs2idx = '0; disp_i_rdidx = '0;
`ifdef EXU_OITF_FLUSH_EN
        flush_req = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset picture
        chk_status("rst", 1'b1, 1'b0, 0);
        check("rst_disp_ptr",  disp_ptr,  0);
        check("rst_ret_ptr",   ret_ptr,   0);
        check("rst_ret_rdwen", ret_rdwen, 0);
        check("rst_ret_rdidx", ret_rdidx, 0);
        chk_haz("rst_haz", 1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 0);

        // Fill: rd=1..4 get itags 0..3; fifth request refused
        do_cycle(1, 1, 5'd1, 1, 2'd0, 0);
        do_cycle(1, 1, 5'd2, 1, 2'd1, 0);
        do_cycle(1, 1, 5'd3, 1, 2'd2, 0);
        do_cycle(1, 1, 5'd4, 1, 2'd3, 0);
        chk_status("full", 1'b0, 1'b1, 4);
        do_cycle(1, 1, 5'd9, 0, 2'd0, 0);
        chk_status("full_ign", 1'b0, 1'b1, 4);
        chk_haz("haz_a", 1, 5'd3, 0, 5'd4, 1, 5'd2, 1, 0, 1);
        chk_haz("haz_b", 1, 5'd7, 1, 5'd4, 0, 5'd2, 0, 1, 0);

        // Retire two, allocate two: allocation pointer wraps to 0,1
        do_cycle(0, 0, 5'd0, 0, 2'd0, 1);
        do_cycle(0, 0, 5'd0, 0, 2'd0, 1);
        chk_status("ret2", 1'b0, 1'b0, 2);
        do_cycle(1, 1, 5'd5, 1, 2'd0, 0);
        do_cycle(1, 1, 5'd0, 1, 2'd1, 0);
        chk_status("wrap", 1'b0, 1'b1, 4);
        chk_haz("haz_c", 1, 5'd5, 0, 5'd5, 1, 5'd4, 1, 0, 1);
        chk_haz("haz_x0", 1, 5'd0, 1, 5'd1, 1, 5'd0, 0, 0, 0);

        // Full with retire and dispatch together: only the retire happens
        do_cycle(1, 1, 5'd7, 0, 2'd0, 1);
        chk_status("full_ret", 1'b0, 1'b0, 3);
        check("full_ret_dptr", disp_ptr, 2);

        // Count 2, then simultaneous alloc and retire keeps count at 2
        do_cycle(0, 0, 5'd0, 0, 2'd0, 1);
        chk_status("cnt2", 1'b0, 1'b0, 2);
        do_cycle(1, 1, 5'd6, 1, 2'd2, 1);
        chk_status("both", 1'b0, 1'b0, 2);

        // Drain; the x0 entry retires with rdwen 0
        do_cycle(0, 0, 5'd0, 0, 2'd0, 1);
        do_cycle(0, 0, 5'd0, 0, 2'd0, 1);
        chk_status("drain", 1'b1, 1'b0, 0);
        check("drain_rdwen", ret_rdwen, 0);

        // Retire while empty is ignored
        do_cycle(0, 0, 5'd0, 0, 2'd0, 1);
        chk_status("emp_ret", 1'b1, 1'b0, 0);
        check("emp_ret_ptr", ret_ptr, 3);

        // Allocate into empty FIFO: ret_* show it on the next cycle
        do_cycle(1, 1, 5'd8, 1, 2'd3, 0);
        check("new_ret_ptr",   ret_ptr,   3);
        check("new_ret_rdidx", ret_rdidx, 8);
        check("new_ret_rdwen", ret_rdwen, 1);
        chk_status("new", 1'b0, 1'b0, 1);
        do_cycle(0, 0, 5'd0, 0, 2'd0, 1);
        chk_status("new_drain", 1'b1, 1'b0, 0);

        // Reset mid-operation overrides same-cycle dispatch and retire
        do_cycle(1, 1, 5'd9,  1, 2'd0, 0);
        do_cycle(1, 1, 5'd10, 1, 2'd1, 0);
        rst_n = 1'b0;
        disp_ena = 1'b1; disp_i_rdwen = 1'b1; disp_i_rdidx = 5'd11; ret_ena = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        disp_ena = 1'b0; disp_i_rdwen = 1'b0; disp_i_rdidx = '0; ret_ena = 1'b0;
        exp_q.delete();
        chk_status("mid_rst", 1'b1, 1'b0, 0);
        check("mid_rst_dptr",  disp_ptr,  0);
        check("mid_rst_rdidx", ret_rdidx, 0);
        chk_haz("mid_rst_haz", 1, 5'd9, 1, 5'd10, 0, 5'd0, 0, 0, 0);

`ifdef EXU_OITF_FLUSH_EN
        // Flush with count 3 and a same-cycle dispatch
        do_cycle(1, 1, 5'd1, 1, 2'd0, 0);
        do_cycle(1, 1, 5'd2, 1, 2'd1, 0);
        do_cycle(1, 1, 5'd3, 1, 2'd2, 0);
        chk_status("pre_flush", 1'b0, 1'b0, 3);
        flush_req = 1'b1;
        disp_ena = 1'b1; disp_i_rdwen = 1'b1; disp_i_rdidx = 5'd4;
        #1;
        check("flush_ready", disp_ready, 0);
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        disp_ena = 1'b0; disp_i_rdwen = 1'b0; disp_i_rdidx = '0;
        exp_q.delete();
        chk_status("flush", 1'b1, 1'b0, 0);
        check("flush_dptr", disp_ptr, 0);
        chk_haz("flush_haz", 1, 5'd4, 1, 5'd1, 0, 5'd0, 0, 0, 0);
        do_cycle(1, 1, 5'd5, 1, 2'd0, 0);
        do_cycle(0, 0, 5'd0, 0, 2'd0, 1);
        chk_status("post_flush", 1'b1, 1'b0, 0);
`endif

        repeat (2) @(posedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
